pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
Program-counter and instruction-fetch stage directly upstream of the register/ALU datapath. Holds the PC and fetches 32-bit instructions from instruction memory over a req/valid handshake. Presents the latched instruction to the control unit, and supplies PC4 to the datapath's PC write-back path. Applies the 2-bit PS next-PC select, using the datapath's PCin (K or register A), when the control unit signals instruction completion.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
CNT_W, 32, width of the retired-instruction counter

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
PS  input  2  next-PC select from control word: 00 hold, 01 PC+4, 10 absolute PCin, 11 PC-relative
PCin  input  64  branch operand from datapath (K or A)
step  input  1  control unit: current instruction complete, apply PS this cycle
imem_req  output  1  fetch request, held until imem_valid
imem_addr  output  64  fetch address (equals PC)
imem_valid  input  1  instruction memory response valid
imem_data  input  32  instruction word, sampled when imem_valid
instr  output  32  latched instruction register (IR)
instr_valid  output  1  IR holds the current instruction; control may execute
PC  output  64  current program counter
PC4  output  64  PC+4, feeds datapath EN_PC source
retired  output  CNT_W  count of completed instructions
fault  output  1  sticky misaligned-target flag

Behaviour:
- States: FETCH, EXEC, HALT. Reset gives state=FETCH, PC=RESET_PC, instr=0, instr_valid=0, retired=0, fault=0.
- imem_req = (state==FETCH) && !reset. imem_addr = PC at all times.
- PC4 = PC+4, combinational, modulo 2^64 (FFFF_FFFF_FFFF_FFFC+4 = 0).
- FETCH:
  - On imem_valid, IR<=imem_data, instr_valid<=1, state<=EXEC. Response latency is unbounded; zero-wait (valid in the first req cycle) is legal.
  - step is ignored in FETCH.
- EXEC:
  - IR and instr_valid are stable. imem_valid is ignored.
  - The control unit may take any number of cycles. On step, compute the target:
    - PS=00: target = PC (refetch same address, spin/halt-in-place).
    - PS=01: target = PC+4.
    - PS=10: target = PCin.
    - PS=11: target = PC + (PCin<<2). PCin is a signed word offset; result taken modulo 2^64.
  - If target[1:0]==0: PC<=target, instr_valid<=0, retired<=retired+1 (wraps at 2^CNT_W), state<=FETCH.
  - If target[1:0]!=0: PC unchanged, fault<=1, instr_valid<=0, retired unchanged, state<=HALT.
- HALT: no request, instr_valid=0, step and imem_valid ignored. Only reset exits HALT.
- Next fetch begins the cycle after step, giving a minimum of 2 cycles per instruction (FETCH+EXEC) with zero-wait memory.
- Reset mid-FETCH or mid-EXEC: reset dominates all inputs. Instruction memory shares reset and abandons any outstanding request; an imem_valid arriving in the reset cycle is ignored.
- PS and PCin are sampled only in the step cycle.

Decomposition:
- Shared package: PS encodings (PS_HOLD=2'b00, PS_INC=2'b01, PS_ABS=2'b10, PS_REL=2'b11), state encoding, instruction width 32, address width 64. The same constants are used by the control-word packer that drives the datapath.
- One natural sub-module: pc_next_calc, a combinational target + misalignment check taking PC, PS and PCin. Keep the FSM, IR, counter and PC register in the top.

Test Plan:
- Reset then zero-wait memory returning 32'hD2800020 with PS=01 and step one cycle after instr_valid: PC steps 0,4,8 every 2 cycles; retired increments 1,2,3; imem_req high on every FETCH cycle.
- Memory with 3-cycle latency: imem_req held 3 cycles with imem_addr stable; instr_valid rises the cycle after imem_valid; a step pulsed during FETCH has no effect.
- PS=11 with PCin=64'hFFFF_FFFF_FFFF_FFFE at PC=0x100: next PC=0xF8. PS=10 with PCin=0x2000: PC=0x2000, refetched there.
- PS=10 with PCin=0x2002: fault=1, state HALT, imem_req=0, PC unchanged, retired unchanged. Later steps are ignored; reset clears fault and gives PC=RESET_PC.
- PC=FFFF_FFFF_FFFF_FFFC: PC4=0, and PS=01 wraps PC to 0 without fault. PS=00 refetches the same address and still increments retired.
- Reset asserted while imem_valid is high in FETCH, and again mid-EXEC: IR stays 0, instr_valid=0, and the first request after release is at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants for the PC/fetch stage and the control-word packer:
// next-PC select encodings, FSM state codes, bus widths and the
// result type of the next-PC calculator.
package pc_fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  // Next-PC select field of the control word.
  typedef enum logic [1:0] {
    PS_HOLD = 2'b00,
    PS_INC  = 2'b01,
    PS_ABS  = 2'b10,
    PS_REL  = 2'b11
  } ps_e;

  // Fetch FSM state codes, kept as plain constants for legacy tooling.
  localparam logic [1:0] ST_FETCH = 2'b00;
  localparam logic [1:0] ST_EXEC  = 2'b01;
  localparam logic [1:0] ST_HALT  = 2'b10;

  // Byte stride between consecutive instructions.
  localparam logic [ADDR_W-1:0] INSTR_BYTES = 64'd4;

  // Candidate next PC plus its word-alignment verdict.
  typedef struct packed {
    logic [ADDR_W-1:0] target;
    logic              misaligned;
  } next_pc_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bus. The fetch unit is the master;
// the instruction memory is the slave.
interface pc_fetch_unit_if;
  import pc_fetch_unit_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_data
  );

endinterface

// File: rtl/pc_fetch_unit_pc_next_calc.sv
// Combinational next-PC calculator: picks the branch target from the
// select code and flags targets that are not word aligned.
module pc_next_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        ps,
  input  logic [ADDR_W-1:0] pc_in,
  output next_pc_t          nxt
);

  logic [ADDR_W-1:0] target;

  // Select the candidate target; PC-relative offsets are signed word counts.
  always_comb begin
    // NOTE: assigning a default before the case keeps this block free of inferred latches.
    target = pc;
    case (ps)
      PS_HOLD: target = pc;
      PS_INC:  target = pc + INSTR_BYTES;
      PS_ABS:  target = pc_in;
      PS_REL:  target = pc + (pc_in << 2);
      default: target = pc;
    endcase
  end

  assign nxt.target     = target;
  assign nxt.misaligned = |target[1:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage. Fetches one instruction at
// a time over the imem bus, holds it in the IR until the control unit
// signals completion, then applies the next-PC select. A misaligned
// target latches a sticky fault and parks the unit until reset.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
  parameter int                CNT_W    = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         PS,
  input  logic [ADDR_W-1:0]  PCin,
  input  logic               step,
  pc_fetch_unit_if.master    imem,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  PC,
  output logic [ADDR_W-1:0]  PC4,
  output logic [CNT_W-1:0]   retired,
  output logic               fault
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0] state;
  next_pc_t   nxt;

  pc_next_calc u_next (
    .pc    (PC),
    .ps    (PS),
    .pc_in (PCin),
    .nxt   (nxt)
  );

  // Request only while fetching; reset withdraws the request in the same cycle
  // because the memory abandons outstanding requests on reset.
  assign imem.imem_req  = (state == ST_FETCH) && !reset;
  assign imem.imem_addr = PC;
  assign PC4            = PC + INSTR_BYTES;

  // Fetch/execute/halt sequencing with IR, PC, retire counter and fault flag.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state       <= ST_FETCH;
      PC          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      retired     <= '0;
      fault       <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem.imem_valid) begin
            instr       <= imem.imem_data;
            instr_valid <= 1'b1;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (step) begin
            instr_valid <= 1'b0;
            if (nxt.misaligned) begin
              fault <= 1'b1;
              state <= ST_HALT;
            end else begin
              PC      <= nxt.target;
              retired <= retired + CNT_ONE;
              state   <= ST_FETCH;
            end
          end
        end
        ST_HALT: state <= ST_HALT;
        default: begin
          instr_valid <= 1'b0;
          state       <= ST_HALT;
        end
      endcase
    end
  end

endmodule
